// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-bus signals of mem_port_arbiter. "master" is the arbiter's view
// (it masters the shared memory port); "slave" is the requesters/memory environment.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ready;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory/IO port between the CPU and a DMA master, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU wins every tie.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter logic [7:0]  TIMEOUT = 8'd64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus,
  output logic [1:0]         owner,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          dma_ready_q, dma_ready_d;
  logic [1:0]    owner_q, owner_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          grant_dma;
  logic          timed_out;
  logic          finish;
`ifdef MEM_ARB_RR_EN
  logic          last_dma_q, last_dma_d;
`endif

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not win last time gets the port.
    if (bus.cpu_req && bus.dma_req) begin
      grant_dma = ~last_dma_q;
    end else begin
      grant_dma = bus.dma_req;
    end
`else
    grant_dma = bus.dma_req && !bus.cpu_req;
`endif
  end

  assign timed_out = (TIMEOUT != 8'd0) && (cnt_q == TIMEOUT);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    owner_d     = owner_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    finish      = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_dma_d  = last_dma_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          state_d   = BUSY;
          mem_req_d = 1'b1;
          cnt_d     = 8'd0;
          if (grant_dma) begin
            owner_d     = OWN_DMA;
            mem_we_d    = bus.dma_we;
            mem_addr_d  = bus.dma_addr;
            mem_wdata_d = bus.dma_wdata;
          end else begin
            owner_d     = OWN_CPU;
            mem_we_d    = bus.cpu_we;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
          end
`ifdef MEM_ARB_RR_EN
          last_dma_d = grant_dma;
`endif
        end
      end

      BUSY: begin
        // An acknowledge in the same cycle as the timeout still delivers real data.
        if (bus.mem_ack) begin
          finish = 1'b1;
          if (!mem_we_q) begin
            if (owner_q == OWN_DMA) begin
              dma_rdata_d = bus.mem_rdata;
            end else begin
              cpu_rdata_d = bus.mem_rdata;
            end
          end
        end else if (timed_out) begin
          finish = 1'b1;
          err_d  = 1'b1;
          if (!mem_we_q) begin
            if (owner_q == OWN_DMA) begin
              dma_rdata_d = '0;
            end else begin
              cpu_rdata_d = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end

        if (finish) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          owner_d     = OWN_NONE;
          cpu_ready_d = (owner_q == OWN_CPU);
          dma_ready_d = (owner_q == OWN_DMA);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        owner_d   = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      owner_q     <= OWN_NONE;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
`ifdef MEM_ARB_RR_EN
      last_dma_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef MEM_ARB_RR_EN
      last_dma_q  <= last_dma_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dma_ready = dma_ready_q;
  assign owner         = owner_q;
  assign err           = err_q;

  // The bus is only requested while someone owns it, and only one requester completes.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset)
    !(cpu_ready_q && dma_ready_q));
  a_req_has_owner: assert property (@(posedge clk) disable iff (!reset)
    mem_req_q |-> (owner_q != OWN_NONE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, reset corner case,
// then random traffic against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int TIMEOUT_CYC = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        cpu_req;
    logic        dma_req;
    logic        cpu_we;
    logic        dma_we;
    logic [31:0] cpu_addr;
    logic [31:0] dma_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] dma_wdata;
    int          ack_delay;
    logic [31:0] mem_rdata;
    logic [1:0]  exp_owner;
    logic [31:0] exp_cpu_rdata;
    logic [31:0] exp_dma_rdata;
    logic        exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] owner;
  logic       err;
  int         checks = 0;
  int         failures = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .owner (owner),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic cr, input logic dr, input logic cw, input logic dw,
                              input logic [31:0] ca, input logic [31:0] da,
                              input logic [31:0] cwd, input logic [31:0] dwd,
                              input int dly, input logic [31:0] mr, input logic [1:0] own,
                              input logic [31:0] ecr, input logic [31:0] edr, input logic ee);
    vec_t v;
    v.cpu_req = cr;  v.dma_req = dr;  v.cpu_we = cw;  v.dma_we = dw;
    v.cpu_addr = ca; v.dma_addr = da; v.cpu_wdata = cwd; v.dma_wdata = dwd;
    v.ack_delay = dly; v.mem_rdata = mr; v.exp_owner = own;
    v.exp_cpu_rdata = ecr; v.exp_dma_rdata = edr; v.exp_err = ee;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  // ack_delay < 0 means the memory never acknowledges.
  task automatic applyStimulus(input vec_t v, input string tag);
    int  busy_cycles;
    logic win_dma;
    win_dma = (v.exp_owner == 2'b10);
    busy_cycles = (v.ack_delay < 0) ? TIMEOUT_CYC + 1 : v.ack_delay + 1;
    bus.cpu_req   = v.cpu_req;   bus.dma_req   = v.dma_req;
    bus.cpu_we    = v.cpu_we;    bus.dma_we    = v.dma_we;
    bus.cpu_addr  = v.cpu_addr;  bus.dma_addr  = v.dma_addr;
    bus.cpu_wdata = v.cpu_wdata; bus.dma_wdata = v.dma_wdata;
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    for (int k = 1; k <= busy_cycles; k++) begin
      @(negedge clk);
      checkOutput({tag, " busy mem_req"}, 64'(bus.mem_req), 64'd1);
      checkOutput({tag, " busy owner"}, 64'(owner), 64'(v.exp_owner));
      checkOutput({tag, " busy mem_we"}, 64'(bus.mem_we), 64'(win_dma ? v.dma_we : v.cpu_we));
      checkOutput({tag, " busy mem_addr"}, 64'(bus.mem_addr), 64'(win_dma ? v.dma_addr : v.cpu_addr));
      checkOutput({tag, " busy mem_wdata"}, 64'(bus.mem_wdata), 64'(win_dma ? v.dma_wdata : v.cpu_wdata));
      checkOutput({tag, " busy ready"}, 64'({bus.cpu_ready, bus.dma_ready}), 64'd0);
      bus.mem_ack   = (k == v.ack_delay + 1);
      bus.mem_rdata = (k == v.ack_delay + 1) ? v.mem_rdata : $urandom;
    end
    @(negedge clk);
    checkOutput({tag, " resp cpu_ready"}, 64'(bus.cpu_ready), 64'(!win_dma));
    checkOutput({tag, " resp dma_ready"}, 64'(bus.dma_ready), 64'(win_dma));
    checkOutput({tag, " resp mem_req"}, 64'(bus.mem_req), 64'd0);
    checkOutput({tag, " resp owner"}, 64'(owner), 64'd0);
    checkOutput({tag, " resp cpu_rdata"}, 64'(bus.cpu_rdata), 64'(v.exp_cpu_rdata));
    checkOutput({tag, " resp dma_rdata"}, 64'(bus.dma_rdata), 64'(v.exp_dma_rdata));
    checkOutput({tag, " resp err"}, 64'(err), 64'(v.exp_err));
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    if (win_dma) bus.dma_req = 1'b0;
    else         bus.cpu_req = 1'b0;
    @(negedge clk);
    checkOutput({tag, " idle ready"}, 64'({bus.cpu_ready, bus.dma_ready}), 64'd0);
    checkOutput({tag, " idle mem_req"}, 64'(bus.mem_req), 64'd0);
    checkOutput({tag, " idle owner"}, 64'(owner), 64'd0);
  endtask

  vec_t vecs [9];
  vec_t r;
  logic m_last_dma;
  logic m_err;
  logic [31:0] m_cpu_rdata, m_dma_rdata;
  logic win_dma, win_we;
  int   d;

  initial begin
    vecs[0] = mk(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 32'h2402_0005,
                 2'b01, 32'h2402_0005, 32'h0, 0);
    vecs[1] = mk(0, 1, 0, 1, 32'h0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 32'h1234_5678,
                 2'b10, 32'h2402_0005, 32'h0, 0);
    vecs[2] = mk(1, 1, 0, 0, 32'h20, 32'h200, 32'h0, 32'h0, 0, 32'h1111_1111,
                 2'b01, 32'h1111_1111, 32'h0, 0);
    vecs[3] = mk(1, 1, 0, 0, 32'h20, 32'h200, 32'h0, 32'h0, 0, 32'h2222_2222,
                 RR ? 2'b10 : 2'b01, RR ? 32'h1111_1111 : 32'h2222_2222,
                 RR ? 32'h2222_2222 : 32'h0, 0);
    vecs[4] = mk(1, 1, 0, 0, 32'h20, 32'h200, 32'h0, 32'h0, 0, 32'h3333_3333,
                 2'b01, 32'h3333_3333, RR ? 32'h2222_2222 : 32'h0, 0);
    vecs[5] = mk(1, 1, 0, 0, 32'h20, 32'h200, 32'h0, 32'h0, 0, 32'h4444_4444,
                 RR ? 2'b10 : 2'b01, RR ? 32'h3333_3333 : 32'h4444_4444,
                 RR ? 32'h4444_4444 : 32'h0, 0);
    vecs[6] = mk(1, 0, 0, 0, 32'h30, 32'h0, 32'h0, 32'h0, -1, 32'h9999_9999,
                 2'b01, 32'h0, RR ? 32'h4444_4444 : 32'h0, 1);
    vecs[7] = mk(0, 1, 0, 0, 32'h0, 32'h300, 32'h0, 32'h0, 1, 32'h55AA_55AA,
                 2'b10, 32'h0, 32'h55AA_55AA, 1);
    vecs[8] = mk(1, 0, 0, 0, 32'h44, 32'h0, 32'h0, 32'h0, 0, 32'h600D_F00D,
                 2'b01, 32'h600D_F00D, 32'h0, 0);

    bus.cpu_req = 0; bus.dma_req = 0; bus.cpu_we = 0; bus.dma_we = 0;
    bus.cpu_addr = 0; bus.dma_addr = 0; bus.cpu_wdata = 0; bus.dma_wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;

    repeat (2) @(negedge clk);
    checkOutput("reset mem_req", 64'(bus.mem_req), 64'd0);
    checkOutput("reset mem_we", 64'(bus.mem_we), 64'd0);
    checkOutput("reset mem_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
    checkOutput("reset rdata", 64'({bus.cpu_rdata, bus.dma_rdata}), 64'd0);
    checkOutput("reset ready", 64'({bus.cpu_ready, bus.dma_ready}), 64'd0);
    checkOutput("reset owner", 64'(owner), 64'd0);
    checkOutput("reset err", 64'(err), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-transaction must clear outputs without a clock edge.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40; bus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("midreset busy mem_req", 64'(bus.mem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset async mem_req", 64'(bus.mem_req), 64'd0);
    checkOutput("midreset async owner", 64'(owner), 64'd0);
    checkOutput("midreset async err", 64'(err), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("midreset no ready", 64'({bus.cpu_ready, bus.dma_ready}), 64'd0);
    end
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("postreset ready", 64'({bus.cpu_ready, bus.dma_ready}), 64'd0);
    checkOutput("postreset mem_req", 64'(bus.mem_req), 64'd0);
    applyStimulus(vecs[8], "vec8");

    // Random traffic: the model reinitialises at a fresh reset and tracks pending requests.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_last_dma = 1'b1; m_err = 1'b0; m_cpu_rdata = '0; m_dma_rdata = '0;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    for (int it = 0; it < 60; it++) begin
      if (!r.cpu_req && $urandom_range(0, 1) == 1) begin
        r.cpu_req = 1'b1; r.cpu_we = 1'($urandom_range(0, 1));
        r.cpu_addr = $urandom; r.cpu_wdata = $urandom;
      end
      if (!r.dma_req && $urandom_range(0, 1) == 1) begin
        r.dma_req = 1'b1; r.dma_we = 1'($urandom_range(0, 1));
        r.dma_addr = $urandom; r.dma_wdata = $urandom;
      end
      if (!r.cpu_req && !r.dma_req) begin
        r.cpu_req = 1'b1; r.cpu_we = 1'($urandom_range(0, 1));
        r.cpu_addr = $urandom; r.cpu_wdata = $urandom;
      end
      if (r.cpu_req && r.dma_req) win_dma = RR ? !m_last_dma : 1'b0;
      else                        win_dma = r.dma_req;
      d = $urandom_range(0, 4);
      r.ack_delay = (d == 4) ? -1 : d;
      r.mem_rdata = $urandom;
      win_we = win_dma ? r.dma_we : r.cpu_we;
      if (!win_we) begin
        if (win_dma) m_dma_rdata = (r.ack_delay < 0) ? 32'h0 : r.mem_rdata;
        else         m_cpu_rdata = (r.ack_delay < 0) ? 32'h0 : r.mem_rdata;
      end
      if (r.ack_delay < 0) m_err = 1'b1;
      r.exp_owner = win_dma ? 2'b10 : 2'b01;
      r.exp_cpu_rdata = m_cpu_rdata;
      r.exp_dma_rdata = m_dma_rdata;
      r.exp_err = m_err;
      applyStimulus(r, $sformatf("rnd%0d", it));
      if (win_dma) r.dma_req = 1'b0;
      else         r.cpu_req = 1'b0;
      m_last_dma = win_dma;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the multi-cycle CPU's single memory/IO port between two requesters: the CPU (instruction fetch and load/store, via `MemRead`/`MemWrite`/`IorD`) and a DMA/peripheral master. It sits between the CPU datapath and the MIO bus. It serialises one transaction at a time and returns a one-cycle `ready` pulse that drives the CPU control FSM's `MIO_ready`. A timeout counter guarantees forward progress if the memory never acknowledges.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 8'd64, cycles in BUSY without `mem_ack` before abort (0 disables timeout; max 255)

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserted (0) forces reset state immediately
- `cpu_req` / `dma_req`  in  1  level request, held until own `*_ready` seen
- `cpu_we` / `dma_we`  in  1  1 = write, 0 = read
- `cpu_addr` / `dma_addr`  in  AW  address
- `cpu_wdata` / `dma_wdata`  in  DW  write data
- `cpu_rdata` / `dma_rdata`  out  DW  registered read data
- `cpu_ready` / `dma_ready`  out  1  one-cycle completion pulse
- `mem_req`  out  1  bus request, registered
- `mem_we`  out  1  registered write enable
- `mem_addr`  out  AW  registered address
- `mem_wdata`  out  DW  registered write data
- `mem_rdata`  in  DW  read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion
- `owner`  out  2  00 none, 01 CPU, 10 DMA
- `err`  out  1  sticky timeout flag

## Operation
- FSM states: IDLE(0), BUSY(1), RESP(2).
- IDLE: if any `*_req`=1, choose winner, latch its `we/addr/wdata` into `mem_*`, set `owner`, go BUSY. Otherwise stay.
- BUSY: `mem_req`=1. On `mem_ack`=1: if read, load `mem_rdata` into winner's `*_rdata`. Go RESP.
- BUSY timeout: an 8-bit counter clears on entry and increments each BUSY cycle without ack. When it equals `TIMEOUT` (nonzero): set `err`=1, load 0 into winner's `*_rdata` if read, go RESP.
- RESP: `mem_req`=0; winner's `*_ready`=1 for exactly this cycle. Next state is IDLE, `owner`=00.
- Writes leave `*_rdata` unchanged.
- Requester protocol: hold req and operands stable until the `ready` cycle; deassert req at the edge ending that cycle.
- req dropped during BUSY: no effect; transaction completes and `ready` still pulses.
- Arbitration with both requests in IDLE: see Configuration. A lone requester always wins.
- `err` clears only on reset.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=`dma_rdata`=0, both `ready`=0, `owner`=00, `err`=0, state IDLE, counter 0, round-robin pointer = DMA-last.
- Req sampled high in IDLE at edge t: `mem_req` high in cycle t+1.
- `mem_ack` in cycle t+1: `ready` high in cycle t+2; back in IDLE at t+3.
- Minimum latency: 2 cycles req-to-ready; 3 cycles per transaction. Back-to-back grants are separated by ≥1 IDLE cycle.
- `mem_ack` outside BUSY is ignored.
- Timeout: `ready` asserts in the cycle after the counter reaches `TIMEOUT`, i.e. `TIMEOUT`+1 BUSY cycles after entry.
- Reset mid-transaction: immediately returns to reset values. The in-flight transaction is abandoned and no `ready` is issued.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. A 1-bit pointer records the last winner; on a tie the other requester wins. The pointer updates on every grant.
- Not defined: fixed priority, CPU always wins ties; DMA may starve. The pointer logic is omitted.

## Test plan
- CPU read alone, addr 0x0000_0010, memory acks in 1st BUSY cycle with 0x2402_0005 -> `cpu_ready` 2 cycles after req, `cpu_rdata`=0x2402_0005, `owner`=01 in BUSY only.
- DMA write addr 0x100, wdata 0xDEAD_BEEF, ack after 3 cycles -> `mem_we`=1, `mem_wdata`=0xDEAD_BEEF held 3 cycles, `dma_ready` 1 pulse, `dma_rdata` unchanged.
- Both req held for 4 transactions, immediate ack -> with `MEM_ARB_RR_EN`: grants CPU, DMA, CPU, DMA. Without it: 4 CPU grants.
- `TIMEOUT`=4, `mem_ack` tied 0, CPU read -> `cpu_ready` after 5 BUSY cycles, `cpu_rdata`=0, `err`=1 and stays 1.
- `reset`=0 asserted mid-BUSY -> `mem_req`, `owner`, `err` go 0 without a clock edge, no `ready` pulse. Next request after release is served normally.
